line_fetch_sched: RTL and testbench
===================================

// Module: line_fetch_sched
// PURPOSE
//  Scanline prefetch scheduler driven by the vga timing generator's sx/sy.
//  At the start of each line it fetches the NEXT displayed line from video memory
//  into the back half of a double line buffer.
//  Fetches are burst reads over a valid/ready request port; returned words are
//  steered into the buffer. Flags underrun when a fetch misses its one-line deadline.
// PARAMETERS
//  CORDW      11    width of sx/sy
//  V_RES      720   active lines (0..V_RES-1)
//  V_TOTAL    741   total lines per frame (last line = V_TOTAL-1)
//  TRIG_X     0     sx value that triggers a fetch
//  WORDS      160   memory words per line; must be a multiple of BURST
//  BURST      16    words per memory request
//  STRIDE     160   address increment between lines (words)
//  BASE       0     frame base address (words)
//  ADDRW      20    memory address width
// PORTS
//  clk_pix      in   1          pixel clock
//  rst_pix      in   1          reset, asynchronous, active-high
//  enable       in   1          1 = triggers honoured; 0 = no new fetches
//  sx           in   CORDW      horizontal position from timing generator
//  sy           in   CORDW      vertical position from timing generator
//  mem_req      out  1          burst read request valid
//  mem_addr     out  ADDRW      burst start address (words)
//  mem_ready    in   1          request accepted when mem_req & mem_ready
//  rd_valid     in   1          one returned data word this cycle (in order)
//  buf_wr_en    out  1          line buffer write strobe
//  buf_wr_addr  out  clog2(WORDS)  word index within line
//  buf_sel      out  1          buffer half being written (= target line[0])
//  disp_sel     out  1          buffer half being displayed (= sy[0], registered)
//  busy         out  1          fetch in progress
//  underrun     out  1          one-cycle pulse: trigger arrived while busy
// BEHAVIOUR
//  - Reset (async): all outputs 0; FSM IDLE; line_addr=BASE; counters 0.
//  - Trigger: enable & sx==TRIG_X & (sy<V_RES-1 | sy==V_TOTAL-1). Target line
//    = sy+1, or 0 when sy==V_TOTAL-1. Other lines: no trigger.
//  - Line address via accumulator, no multiplier: target 0 -> BASE; else
//    previous target address + STRIDE. Address arithmetic wraps mod 2^ADDRW.
//  - FSM IDLE -> REQ on trigger (cycle after trigger: mem_req=1, busy=1,
//    buf_sel = target[0]). REQ: mem_addr = line_addr + issued; on handshake
//    issued += BURST; after the last (WORDS/BURST-th) handshake -> WAIT with
//    mem_req=0 the next cycle. WAIT -> IDLE when returned count reaches WORDS;
//    busy=0 the cycle after the last write.
//  - mem_req/mem_addr held stable while mem_ready=0; mem_req never drops
//    before a handshake.
//  - rd_valid counted in REQ and WAIT (returns may overlap issue): same-cycle
//    buf_wr_en=1, buf_wr_addr=returned (0..WORDS-1), then returned++.
//    rd_valid in IDLE ignored (no write).
//  - Trigger while busy: underrun pulses 1 cycle; trigger dropped; the current
//    fetch continues to completion; line_addr still advances for the dropped line.
//  - enable falling mid-fetch: current fetch completes; no new triggers.
//  - disp_sel registered from sy[0] each cycle (1-cycle latency).
//  - Reset mid-fetch: immediate IDLE; outstanding returns after reset are
//    ignored.
// TESTING
//  1 Assert rst_pix mid-cycle -> all outputs 0 immediately; busy=0;
//    line_addr=BASE.
//  2 sy=0,sx=0, mem_ready=1, rd_valid 4 cycles after each request -> 10 requests
//    at addr 160,176,..,304; buf_sel=1; 160 writes to addr 0..159; busy drops.
//  3 Same as 2 with mem_ready=0 for 20 cycles on 3rd request -> mem_req/mem_addr=192
//    held stable; total still 10 handshakes.
//  4 sy=740,sx=0 -> fetch of line 0: first mem_addr=BASE=0, buf_sel=0;
//    sy=719 -> no trigger.
//  5 Withhold rd_valid after 100 words until next sx==0 -> underrun=1 one cycle,
//    no new mem_req; fetch finishes when words resume.
//  6 enable=0 at sy=5 -> no mem_req for triggers; rd_valid in IDLE ->
//    buf_wr_en stays 0.

Source files
------------

// File: rtl/line_fetch_sched.sv
// Scanline prefetch scheduler: at each trigger point it burst-reads the next
// displayed line from video memory into the back half of a double line buffer.
module line_fetch_sched #(
  parameter int CORDW   = 11,
  parameter int V_RES   = 720,
  parameter int V_TOTAL = 741,
  parameter int TRIG_X  = 0,
  parameter int WORDS   = 160,
  parameter int BURST   = 16,
  parameter int STRIDE  = 160,
  parameter int BASE    = 0,
  parameter int ADDRW   = 20
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix,
  input  logic                      enable,
  input  logic [CORDW-1:0]          sx,
  input  logic [CORDW-1:0]          sy,
  output logic                      mem_req,
  output logic [ADDRW-1:0]          mem_addr,
  input  logic                      mem_ready,
  input  logic                      rd_valid,
  output logic                      buf_wr_en,
  output logic [$clog2(WORDS)-1:0]  buf_wr_addr,
  output logic                      buf_sel,
  output logic                      disp_sel,
  output logic                      busy,
  output logic                      underrun
);

  localparam int WAW    = $clog2(WORDS);
  localparam int NBURST = WORDS / BURST;
  localparam int BCW    = $clog2(NBURST + 1);
  localparam int RCW    = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] line_addr_q, line_addr_d;
  logic [ADDRW-1:0] req_addr_q, req_addr_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [RCW-1:0]   ret_cnt_q, ret_cnt_d;
  logic             buf_sel_q, buf_sel_d;
  logic             disp_sel_q, disp_sel_d;
  logic             underrun_q, underrun_d;

  logic             at_last_line;
  logic             trigger;
  logic             target_lsb;
  logic [ADDRW-1:0] next_line_addr;
  logic             hs;
  logic             wr_fire;
  logic             last_burst;
  logic             ret_done;

  // Trigger decode: the line after the last frame line wraps to line 0.
  always_comb begin
    at_last_line   = (sy == CORDW'(V_TOTAL - 1));
    trigger        = enable && (sx == CORDW'(TRIG_X)) &&
                     ((sy < CORDW'(V_RES - 1)) || at_last_line);
    target_lsb     = at_last_line ? 1'b0 : ~sy[0];
    next_line_addr = at_last_line ? ADDRW'(BASE) : line_addr_q + ADDRW'(STRIDE);
  end

  always_comb begin
    hs         = (state_q == REQ) && mem_ready;
    wr_fire    = rd_valid && (state_q != IDLE) && (ret_cnt_q < RCW'(WORDS));
    last_burst = (burst_cnt_q == BCW'(NBURST - 1));
    ret_done   = (wr_fire && (ret_cnt_q == RCW'(WORDS - 1))) ||
                 (ret_cnt_q == RCW'(WORDS));
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q     <= IDLE;
      line_addr_q <= ADDRW'(BASE);
      req_addr_q  <= '0;
      burst_cnt_q <= '0;
      ret_cnt_q   <= '0;
      buf_sel_q   <= 1'b0;
      disp_sel_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      req_addr_q  <= req_addr_d;
      burst_cnt_q <= burst_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      buf_sel_q   <= buf_sel_d;
      disp_sel_q  <= disp_sel_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = REQ;
      REQ:     if (hs && last_burst) state_d = WAIT;
      WAIT:    if (ret_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The accumulator advances on every trigger, even a dropped one, so the
  // next accepted line still lands on the right address.
  always_comb begin
    line_addr_d = line_addr_q;
    req_addr_d  = req_addr_q;
    burst_cnt_d = burst_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    buf_sel_d   = buf_sel_q;
    disp_sel_d  = sy[0];
    underrun_d  = trigger && (state_q != IDLE);
    if (trigger) line_addr_d = next_line_addr;
    if ((state_q == IDLE) && trigger) begin
      req_addr_d  = next_line_addr;
      burst_cnt_d = '0;
      ret_cnt_d   = '0;
      buf_sel_d   = target_lsb;
    end
    if (hs) begin
      req_addr_d  = req_addr_q + ADDRW'(BURST);
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
    if (wr_fire) ret_cnt_d = ret_cnt_q + 1'b1;
  end

  always_comb begin
    mem_req     = (state_q == REQ);
    mem_addr    = (state_q == REQ) ? req_addr_q : '0;
    busy        = (state_q != IDLE);
    buf_wr_en   = wr_fire;
    buf_wr_addr = ret_cnt_q[WAW-1:0];
    buf_sel     = buf_sel_q;
    disp_sel    = disp_sel_q;
    underrun    = underrun_q;
  end

endmodule

// File: tb/tb_line_fetch_sched.sv
// Self-checking bench for line_fetch_sched: trigger decode table plus
// directed multi-cycle fetch sequences against a small memory model.
module tb_line_fetch_sched;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] sx = 11'd1;
  logic [10:0] sy = 11'd0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic        rd_valid = 1'b0;
  logic        buf_wr_en;
  logic [7:0]  buf_wr_addr;
  logic        buf_sel;
  logic        disp_sel;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int ret_q[$];

  line_fetch_sched dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .enable(enable), .sx(sx), .sy(sy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .rd_valid(rd_valid), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_sel(buf_sel), .disp_sel(disp_sel), .busy(busy), .underrun(underrun)
  );

  initial forever #5 clk_pix = ~clk_pix;

  typedef struct {
    logic        en;
    logic [10:0] vx;
    logic [10:0] vy;
    logic        exp_req;
    logic [19:0] exp_addr;
    logic        exp_sel;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pulseReset();
    rst_pix = 1'b1;
    @(posedge clk_pix); #1;
    rst_pix = 1'b0;
  endtask

  // One trigger-decode vector from a freshly reset scheduler.
  task automatic applyStimulus(input vec_t v);
    pulseReset();
    enable = v.en; sx = v.vx; sy = v.vy; rd_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk_pix); #1;
    sx = 11'd1;
    @(negedge clk_pix);
    checkOutput("tbl_req", mem_req, v.exp_req);
    checkOutput("tbl_busy", busy, v.exp_req);
    checkOutput("tbl_addr", mem_addr, v.exp_addr);
    checkOutput("tbl_sel", buf_sel, v.exp_sel);
    checkOutput("tbl_disp", disp_sel, v.vy[0]);
    checkOutput("tbl_underrun", underrun, 1'b0);
    @(posedge clk_pix); #1;
  endtask

  // Runs one full fetch; memory returns each burst from 4 cycles after its handshake.
  task automatic run_fetch(input int start_sy, input int exp_base, input logic exp_sel,
                           input int stall_hs, input int pause_after, input int pause_len,
                           input bit drop_en);
    int hs = 0, wr = 0, ret_n = 0, ur_cnt = 0, exp_ur_cyc = -1;
    int stall_left = 20, pause_left = pause_len;
    bit last_wr = 0, done = 0;
    ret_q.delete();
    sy = 11'(start_sy); sx = 11'd0; enable = 1'b1; mem_ready = 1'b1; rd_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk_pix);
      if (last_wr) begin
        checkOutput("busy_drop", busy, 1'b0);
        done = 1;
        break;
      end
      if (c > 0 && hs < 10) checkOutput("req_held", mem_req, 1'b1);
      if (mem_req) begin
        checkOutput("req_addr", mem_addr, exp_base + 16 * hs);
        checkOutput("buf_sel", buf_sel, exp_sel);
        if (mem_ready) begin
          hs++;
          for (int k = 0; k < 16; k++) ret_q.push_back(c + 4);
        end
      end
      if (buf_wr_en) begin
        checkOutput("wr_addr", buf_wr_addr, wr);
        wr++;
      end
      if (underrun) ur_cnt++;
      checkOutput("underrun", underrun, c == exp_ur_cyc);
      last_wr = buf_wr_en && (wr == 160);
      @(posedge clk_pix); #1;
      sx = 11'd1;
      if (drop_en) enable = 1'b0;
      mem_ready = !((hs == stall_hs) && (stall_left > 0));
      if (!mem_ready) stall_left--;
      if (pause_after >= 0 && ret_n == pause_after && pause_left > 0) begin
        rd_valid = 1'b0;
        pause_left--;
        if (pause_left == 0) begin
          sx = 11'd0; sy = 11'(start_sy + 1);
          exp_ur_cyc = c + 2;
        end
      end else if (ret_q.size() > 0 && ret_q[0] <= c + 1) begin
        void'(ret_q.pop_front());
        rd_valid = 1'b1;
        ret_n++;
      end else begin
        rd_valid = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL fetch_timeout: got busy=%0d writes=%0d expected completion", busy, wr);
    end
    checkOutput("handshakes", hs, 10);
    checkOutput("writes", wr, 160);
    checkOutput("underrun_cnt", ur_cnt, (pause_after >= 0) ? 1 : 0);
    @(posedge clk_pix); #1;
    rd_valid = 1'b0; sx = 11'd1; enable = 1'b1; mem_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[9];
    vecs[0] = '{1'b1, 11'd0, 11'd0,   1'b1, 20'd160, 1'b1};
    vecs[1] = '{1'b1, 11'd0, 11'd1,   1'b1, 20'd160, 1'b0};
    vecs[2] = '{1'b1, 11'd0, 11'd718, 1'b1, 20'd160, 1'b1};
    vecs[3] = '{1'b1, 11'd0, 11'd719, 1'b0, 20'd0,   1'b0};
    vecs[4] = '{1'b1, 11'd0, 11'd730, 1'b0, 20'd0,   1'b0};
    vecs[5] = '{1'b1, 11'd0, 11'd740, 1'b1, 20'd0,   1'b0};
    vecs[6] = '{1'b1, 11'd0, 11'd739, 1'b0, 20'd0,   1'b0};
    vecs[7] = '{1'b1, 11'd1, 11'd0,   1'b0, 20'd0,   1'b0};
    vecs[8] = '{1'b0, 11'd0, 11'd0,   1'b0, 20'd0,   1'b0};

    repeat (2) @(posedge clk_pix);
    #1 rst_pix = 1'b0;

    // Mid-fetch asynchronous reset with data still arriving.
    enable = 1'b1; sy = 11'd1; sx = 11'd0; mem_ready = 1'b0;
    @(posedge clk_pix); #1;
    sx = 11'd1; rd_valid = 1'b1;
    repeat (3) @(posedge clk_pix);
    #3 rst_pix = 1'b1;
    #1;
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_addr", mem_addr, 20'd0);
    checkOutput("rst_wr_en", buf_wr_en, 1'b0);
    checkOutput("rst_wr_addr", buf_wr_addr, 8'd0);
    checkOutput("rst_buf_sel", buf_sel, 1'b0);
    checkOutput("rst_disp_sel", disp_sel, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_underrun", underrun, 1'b0);
    @(posedge clk_pix); #1;
    rst_pix = 1'b0;
    @(negedge clk_pix);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_wr_en", buf_wr_en, 1'b0);
    checkOutput("post_rst_req", mem_req, 1'b0);
    @(posedge clk_pix); #1;
    rd_valid = 1'b0; mem_ready = 1'b1;

    $display("[TB] basic fetch of line 1");
    run_fetch(0, 160, 1'b1, -1, -1, 0, 1'b0);

    $display("[TB] trigger decode table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] ready stall on third request, enable dropped mid-fetch");
    pulseReset();
    run_fetch(0, 160, 1'b1, 2, -1, 0, 1'b1);

    $display("[TB] wrap from last frame line to line 0");
    pulseReset();
    run_fetch(740, 0, 1'b0, -1, -1, 0, 1'b0);

    $display("[TB] underrun on late fetch, then next line address");
    pulseReset();
    run_fetch(0, 160, 1'b1, -1, 100, 30, 1'b0);
    run_fetch(2, 480, 1'b1, -1, -1, 0, 1'b0);

    $display("[TB] disabled triggers and stray returns in idle");
    enable = 1'b0; sy = 11'd5; sx = 11'd0; rd_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_pix);
      checkOutput("dis_req", mem_req, 1'b0);
      checkOutput("dis_wr_en", buf_wr_en, 1'b0);
      checkOutput("dis_busy", busy, 1'b0);
      @(posedge clk_pix); #1;
      sx = 11'd1;
    end
    rd_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
